// File: rtl/msrv32_imm_generator.sv
// Immediate generator: decodes the RISC-V immediate of the selected format from
// instruction bits [31:7] and registers it, one cycle of latency.
module msrv32_imm_generator (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:7] instr_in,
  input  logic [2:0]  imm_type_in,
  output logic [31:0] imm_out
);

  typedef enum logic [2:0] {
    IMM_R   = 3'b000,
    IMM_I   = 3'b001,
    IMM_S   = 3'b010,
    IMM_B   = 3'b011,
    IMM_U   = 3'b100,
    IMM_J   = 3'b101,
    IMM_CSR = 3'b110
  } imm_type_e;

  logic        sgn;
  logic [31:0] i_imm;
  logic [31:0] imm_d;
  logic [31:0] imm_q;

  // instr_in[31] is the only sign source for every signed format.
  assign sgn   = instr_in[31];
  assign i_imm = {{20{sgn}}, instr_in[31:20]};

  always_comb begin
    imm_d = i_imm;
    case (imm_type_in)
      IMM_R, IMM_I: imm_d = i_imm;
      IMM_S:        imm_d = {{20{sgn}}, instr_in[31:25], instr_in[11:7]};
      IMM_B:        imm_d = {{20{sgn}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
      IMM_U:        imm_d = {instr_in[31:12], 12'h000};
      IMM_J:        imm_d = {{12{sgn}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
      IMM_CSR:      imm_d = {27'b0, instr_in[19:15]};
      default:      imm_d = i_imm;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) imm_q <= 32'h0000_0000;
    else                      imm_q <= imm_d;
  end

  assign imm_out = imm_q;

endmodule

// File: tb/tb_msrv32_imm_generator.sv
// Table-driven check of every immediate format plus async-reset and
// mid-cycle input-change sequences.
module tb_msrv32_imm_generator;

  logic        clk;
  logic        rst;
  logic [31:7] instr_in;
  logic [2:0]  imm_type_in;
  logic [31:0] imm_out;

  int errors = 0;
  int checks = 0;

  msrv32_imm_generator dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .instr_in             (instr_in),
    .imm_type_in          (imm_type_in),
    .imm_out              (imm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  typ;
    logic [31:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [2:0] typ);
    instr_in    = instr[31:7];
    imm_type_in = typ;
  endtask

  initial begin
    vecs[0]  = '{32'hAABBCCDD, 3'd0, 32'hFFFFFAAB, "abcd_r"};
    vecs[1]  = '{32'hAABBCCDD, 3'd1, 32'hFFFFFAAB, "abcd_i"};
    vecs[2]  = '{32'hAABBCCDD, 3'd2, 32'hFFFFFAB9, "abcd_s"};
    vecs[3]  = '{32'hAABBCCDD, 3'd3, 32'hFFFFFAB8, "abcd_b"};
    vecs[4]  = '{32'hAABBCCDD, 3'd4, 32'hAABBC000, "abcd_u"};
    vecs[5]  = '{32'hAABBCCDD, 3'd5, 32'hFFFBCAAA, "abcd_j"};
    vecs[6]  = '{32'hAABBCCDD, 3'd6, 32'h00000017, "abcd_csr"};
    vecs[7]  = '{32'hAABBCCDD, 3'd7, 32'hFFFFFAAB, "abcd_dflt"};
    vecs[8]  = '{32'h7FF00000, 3'd1, 32'h000007FF, "i_pos_max"};
    vecs[9]  = '{32'h800F8000, 3'd6, 32'h0000001F, "csr_nosign"};
    vecs[10] = '{32'hFFFFF000, 3'd4, 32'hFFFFF000, "u_ones"};
    vecs[11] = '{32'h00000080, 3'd3, 32'h00000800, "b_bit11"};
    vecs[12] = '{32'h7FFFF000, 3'd5, 32'h000FFFFE, "j_pos_max"};
    vecs[13] = '{32'h7E000F80, 3'd2, 32'h000007FF, "s_pos_max"};
    vecs[14] = '{32'h80000000, 3'd2, 32'hFFFFF800, "s_sign_only"};
    vecs[15] = '{32'h80000000, 3'd3, 32'hFFFFF000, "b_sign_only"};
    vecs[16] = '{32'h80000000, 3'd5, 32'hFFF00000, "j_sign_only"};
    vecs[17] = '{32'h7FFFFFFF, 3'd3, 32'h00000FFE, "b_pos_lsb0"};

    // Reset applied at time 0: output must be clear before any clock edge.
    rst = 1'b1;
    drive(32'hAABBCCDD, 3'd1);
    #2;
    check("reset_initial", imm_out, 32'h0);
    @(negedge clk);
    check("reset_held", imm_out, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].typ);
      @(posedge clk);
      #1;
      check(vecs[i].name, imm_out, vecs[i].exp);
    end

    // Mid-cycle selector change is invisible until the next rising edge.
    @(negedge clk);
    drive(32'hAABBCCDD, 3'd1);
    @(posedge clk);
    #2;
    imm_type_in = 3'd4;
    #1;
    check("midcycle_hold", imm_out, 32'hFFFFFAAB);
    @(posedge clk);
    #1;
    check("midcycle_update", imm_out, 32'hAABBC000);

    // Async reset between edges while holding FFFFFAAB.
    @(negedge clk);
    drive(32'hAABBCCDD, 3'd1);
    @(posedge clk);
    #1;
    check("pre_reset_val", imm_out, 32'hFFFFFAAB);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset", imm_out, 32'h0);
    @(posedge clk);
    #1;
    check("reset_across_edge", imm_out, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("after_release_noedge", imm_out, 32'h0);
    @(posedge clk);
    #1;
    check("first_edge_after_rel", imm_out, 32'hFFFFFAAB);

    // Selector driven to unknown falls back to the I-type result.
    @(negedge clk);
    instr_in    = 25'h0;
    imm_type_in = 3'bxxx;
    instr_in    = 25'(32'hAABBCCDD >> 7);
    @(posedge clk);
    #1;
    check("x_selector", imm_out, 32'hFFFFFAAB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
